// File: rtl/alg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alg_pkg
// Purpose  : Shared ALG constants, nrise FSM encoding and saturation helper.
// Revision : 1.0 - initial release
// ============================================================================
package alg_pkg;

   localparam int ALG_NRISE_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } alg_nrise_state_t;

   function automatic int alg_sat_lim(input int w);
      return (1 << w) - 1;
   endfunction

   localparam int ALG_NRISE_SAT = alg_sat_lim(ALG_NRISE_W);

endpackage
`default_nettype wire

// File: rtl/alg_nrise_count_if.sv
`default_nettype none
// ============================================================================
// Module   : alg_nrise_count_if
// Purpose  : Control/result bundle between the comparator path and nrise count.
// Revision : 1.0 - initial release
// ============================================================================
interface alg_nrise_count_if #(
   parameter int CNT_W = alg_pkg::ALG_NRISE_W
);
   logic             en;
   logic             sig_in;
   logic [CNT_W-1:0] nrise;
   logic             nrise_vld;
   logic             sat;

   modport master (output en, sig_in, input nrise, nrise_vld, sat);
   modport slave  (input en, sig_in, output nrise, nrise_vld, sat);
endinterface
`default_nettype wire

// File: rtl/alg_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : alg_edge_det
// Purpose  : Optional 2-flop sync (ALG_NRISE_SYNC_EN), s_prev and rise pulse.
// Revision : 1.0 - initial release
// ============================================================================
module alg_edge_det (
   input  wire  clk,
   input  wire  rst,
   input  wire  i_sig,
   input  wire  i_arm,
   input  wire  i_run,
   output logic o_edge
);

   logic w_s;
   logic r_s_prev;

`ifdef ALG_NRISE_SYNC_EN
   logic r_sync1;
   logic r_sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_sig;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = r_sync2;
`else
   assign w_s = i_sig;
`endif

   // The ARM load makes the level present at enable the reference, not an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s_prev <= 1'b0;
      end else if (i_arm || i_run) begin
         r_s_prev <= w_s;
      end
   end

   assign o_edge = i_run & w_s & ~r_s_prev;

endmodule
`default_nettype wire

// File: rtl/alg_nrise_count.sv
`default_nettype none
// ============================================================================
// Module   : alg_nrise_count
// Purpose  : Windowed rising-edge counter producing saturated nrise code.
//            Input synchronizer enabled by defining ALG_NRISE_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alg_nrise_count
   import alg_pkg::*;
#(
   parameter int WIN_LEN = 64,
   parameter int CNT_W   = ALG_NRISE_W
) (
   input  wire              clk,
   input  wire              rst,
   alg_nrise_count_if.slave bus
);

   localparam int                c_WC_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam logic [c_WC_W-1:0] c_WC_LAST = c_WC_W'(WIN_LEN - 1);
   localparam logic [c_WC_W-1:0] c_WC_ONE  = c_WC_W'(1);
   localparam logic [CNT_W-1:0]  c_SAT_LIM = CNT_W'(alg_sat_lim(CNT_W));
   localparam logic [CNT_W-1:0]  c_ACC_ONE = CNT_W'(1);

   alg_nrise_state_t  r_state;
   logic [c_WC_W-1:0] r_wcnt;
   logic [CNT_W-1:0]  r_acc;
   logic              r_ovf;
   logic [CNT_W-1:0]  r_nrise;
   logic              r_sat;
   logic              r_vld;

   logic              w_arm;
   logic              w_run;
   logic              w_edge;
   logic              w_full;
   logic              w_term;
   logic [CNT_W-1:0]  w_acc_nxt;

   assign w_arm     = (r_state == ST_ARM);
   assign w_run     = (r_state == ST_RUN);
   assign w_full    = (r_acc == c_SAT_LIM);
   assign w_term    = w_run && (r_wcnt == c_WC_LAST);
   assign w_acc_nxt = (w_edge && !w_full) ? (r_acc + c_ACC_ONE) : r_acc;

   alg_edge_det u_edge_det (
      .clk    (clk),
      .rst    (rst),
      .i_sig  (bus.sig_in),
      .i_arm  (w_arm),
      .i_run  (w_run),
      .o_edge (w_edge)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_wcnt  <= '0;
         r_acc   <= '0;
         r_ovf   <= 1'b0;
         r_nrise <= '0;
         r_sat   <= 1'b0;
         r_vld   <= 1'b0;
      end else begin
         r_vld <= 1'b0;
         if (!bus.en) begin
            // Partial window is dropped; published results stay as they were.
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state <= ST_ARM;
                  r_wcnt  <= '0;
                  r_acc   <= '0;
                  r_ovf   <= 1'b0;
               end
               ST_ARM: begin
                  r_state <= ST_RUN;
                  r_wcnt  <= '0;
                  r_acc   <= '0;
                  r_ovf   <= 1'b0;
               end
               ST_RUN: begin
                  if (w_term) begin
                     // A terminal-cycle edge closes with this window; next starts gap-free.
                     r_nrise <= w_acc_nxt;
                     r_sat   <= r_ovf | (w_edge & w_full);
                     r_vld   <= 1'b1;
                     r_wcnt  <= '0;
                     r_acc   <= '0;
                     r_ovf   <= 1'b0;
                  end else begin
                     r_wcnt <= r_wcnt + c_WC_ONE;
                     r_acc  <= w_acc_nxt;
                     if (w_edge && w_full) begin
                        r_ovf <= 1'b1;
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.nrise     = r_nrise;
   assign bus.sat       = r_sat;
   assign bus.nrise_vld = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_alg_nrise_count.sv
`default_nettype none
// ============================================================================
// Module   : tb_alg_nrise_count
// Purpose  : Directed self-checking bench for alg_nrise_count (WIN_LEN = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alg_nrise_count;

   localparam int c_WIN = 16;
   localparam int c_CW  = 3;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   typedef struct {
      int cyc;
      int nrise;
      int sat;
   } strobe_t;

   strobe_t q[$];

   alg_nrise_count_if #(.CNT_W(c_CW)) bus ();

   alg_nrise_count #(
      .WIN_LEN (c_WIN),
      .CNT_W   (c_CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.nrise_vld === 1'b1) begin
         q.push_back('{cyc, int'(bus.nrise), int'(bus.sat)});
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_wave(input int per, input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         bus.sig_in = ((k % per) >= (per / 2));
         tick(1);
      end
   endtask

   task automatic drive_bits(input logic [63:0] bits, input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         bus.sig_in = bits[k];
         tick(1);
      end
   endtask

   // First strobe lands WIN_LEN+2 cycles after enable, then every WIN_LEN.
   task automatic check_win(input string tag, input int base, input int n,
                            input int exp_n[3], input int exp_s[3]);
      chk({tag, "_strobes"}, q.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < q.size()) begin
            chk($sformatf("%s_w%0d_time", tag, i), q[i].cyc - base, c_WIN + 2 + c_WIN * i);
            chk($sformatf("%s_w%0d_nrise", tag, i), q[i].nrise, exp_n[i]);
            chk($sformatf("%s_w%0d_sat", tag, i), q[i].sat, exp_s[i]);
         end
      end
   endtask

   initial begin
      int base;
      bus.en     = 1'b0;
      bus.sig_in = 1'b0;

      // Reset held while the input toggles.
      for (int k = 0; k < 4; k++) begin
         bus.sig_in = ~bus.sig_in;
         tick(1);
      end
      chk("rst_nrise", bus.nrise, 0);
      chk("rst_vld", bus.nrise_vld, 0);
      chk("rst_sat", bus.sat, 0);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         bus.sig_in = ~bus.sig_in;
         tick(1);
      end
      chk("idle_no_strobe", q.size(), 0);
      chk("idle_nrise", bus.nrise, 0);
      bus.sig_in = 1'b0;
      tick(2);

      // Period-4 square wave: 4 rises per window.
      q.delete();
      base   = cyc;
      bus.en = 1'b1;
      drive_wave(4, 54);
      bus.en = 1'b0;
      bus.sig_in = 1'b0;
      tick(3);
      check_win("sq4", base, 3, '{4, 4, 4}, '{0, 0, 0});

      // Period-2 square wave: 8 rises saturate to 7.
      q.delete();
      base   = cyc;
      bus.en = 1'b1;
      drive_wave(2, 38);
      bus.en = 1'b0;
      bus.sig_in = 1'b0;
      tick(3);
      check_win("sq2", base, 2, '{7, 7, 0}, '{1, 1, 0});

      // High at enable, then three rises.
      q.delete();
      base       = cyc;
      bus.en     = 1'b1;
      drive_bits(64'b000000000000_1010101111, 22);
      bus.en     = 1'b0;
      bus.sig_in = 1'b0;
      tick(3);
      check_win("lvl", base, 1, '{3, 0, 0}, '{0, 0, 0});

      // Rise in terminal cycle of window 0, rise in first cycle of window 2.
      q.delete();
      base   = cyc;
      bus.en = 1'b1;
      drive_bits((64'd1 << 17) | (64'd1 << 34), 54);
      bus.en = 1'b0;
      bus.sig_in = 1'b0;
      tick(3);
      check_win("bnd", base, 3, '{1, 0, 1}, '{0, 0, 0});

      // Abort at window cycle 10, then re-enable.
      q.delete();
      base   = cyc;
      bus.en = 1'b1;
      drive_wave(4, 28);
      bus.en     = 1'b0;
      bus.sig_in = 1'b0;
      tick(5);
      check_win("abort", base, 1, '{4, 0, 0}, '{0, 0, 0});
      chk("abort_hold_nrise", bus.nrise, 4);
      chk("abort_hold_sat", bus.sat, 0);
      q.delete();
      base   = cyc;
      bus.en = 1'b1;
      drive_wave(2, 22);
      bus.en     = 1'b0;
      bus.sig_in = 1'b0;
      tick(3);
      check_win("reen", base, 1, '{7, 0, 0}, '{1, 0, 0});

      // Asynchronous reset mid-window.
      q.delete();
      bus.en = 1'b1;
      drive_wave(2, 10);
      chk("pre_rst_nrise", bus.nrise, 7);
      chk("pre_rst_sat", bus.sat, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_nrise", bus.nrise, 0);
      chk("arst_sat", bus.sat, 0);
      chk("arst_vld", bus.nrise_vld, 0);
      bus.en     = 1'b0;
      bus.sig_in = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(4);
      chk("arst_no_strobe", q.size(), 0);
      chk("arst_hold_nrise", bus.nrise, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alg_nrise_count.md
# alg_nrise_count

Rising-edge counter that produces the 3-bit `nrise` code consumed by `alg_autocor`. It samples the 1-bit comparator output of the analog front end and counts rising edges over a fixed window of clock cycles. At each window end it publishes a saturated count with a one-cycle valid strobe. It sits between the front-end comparator and the autocorrelation increment lookup in the PLL loop.

## Interface
- `WIN_LEN`, 64: window length in clock cycles; legal range 8..1024.
- `CNT_W`, 3: width of `nrise`; saturation value is 2^CNT_W-1.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `en` input 1: counting enable; low forces IDLE.
- `sig_in` input 1: comparator output to be edge-counted.
- `nrise` output CNT_W: rising-edge count of the last completed window, saturated.
- `nrise_vld` output 1: one-cycle strobe when `nrise` updates.
- `sat` output 1: last completed window saturated (raw count > 2^CNT_W-1).

## Operation
- Sampled signal `s`: `sig_in`, or its synchronized version (see Configuration). `s_prev` holds `s` from the previous cycle.
- Edge condition: `s`=1 and `s_prev`=0 in the same cycle.
- FSM states are IDLE, ARM and RUN.
- IDLE:
  - Window counter = 0, accumulator = 0.
  - `en`=1 -> ARM.
- ARM, one cycle:
  - Loads `s_prev` <= `s`, so the level present at enable is never counted as an edge.
  - Clears the counters -> RUN.
- RUN:
  - Window counter increments every cycle, from 0 to WIN_LEN-1.
  - Accumulator increments on each edge and saturates at 2^CNT_W-1.
  - Internal overflow bit set if an edge occurs while the accumulator is already saturated.
- Terminal cycle (window counter = WIN_LEN-1):
  - `nrise` <= accumulator plus this cycle's edge, saturated.
  - `sat` <= overflow, or an edge arriving on a saturated accumulator.
  - `nrise_vld` <= 1.
  - Accumulator, overflow and window counter clear. FSM stays in RUN and the next window starts with no gap.
- `en`=0 in any state -> IDLE next cycle. The partial window is discarded; `nrise` and `sat` hold their last published values and no strobe is issued.
- An edge in the terminal cycle belongs to the closing window. An edge in the first cycle of the next window belongs to the new window.
- Reset:
  - `nrise`=0, `nrise_vld`=0, `sat`=0, state IDLE, all counters 0, `s_prev`=0, synchronizer flops 0.
  - Reset asserted mid-window drops the window with no strobe.

## Timing
- The edge-to-count path is registered, with no combinational path from input to output.
- With `en` rising at cycle 0: ARM at cycle 1, RUN from cycle 2, first `nrise_vld` at cycle 2+WIN_LEN.
- Strobes then repeat every WIN_LEN cycles.
- `nrise` and `sat` change only in the cycle `nrise_vld` is high, and are stable otherwise.
- Maximum countable rate is one edge per 2 cycles, since `s` must return low between edges.

## Configuration
- `ALG_NRISE_SYNC_EN` defined:
  - `sig_in` passes through a two-flop synchronizer before edge detection.
  - Edge detection lags `sig_in` by 2 extra cycles.
  - Window timing is unchanged.
- Undefined: `sig_in` is used directly; for testbench and simulation use with a clock-aligned input only.

## Structure
- Shared package `alg_pkg` holds:
  - `ALG_NRISE_W` = 3, shared with `alg_autocor`.
  - The FSM state encoding: IDLE=2'd0, ARM=2'd1, RUN=2'd2.
  - A saturation-limit constant.
- One sub-module, `alg_edge_det`: optional synchronizer, `s_prev` register and rising-edge pulse, with an arm input for the ARM load.
- The window counter, accumulator and FSM stay in the top module.

## Test plan
- Reset with `sig_in` toggling -> all outputs 0, no strobe until `en` rises.
- `WIN_LEN`=16, `en` high, `sig_in` square wave with period 4 cycles -> `nrise`=4, `sat`=0 on every strobe, strobes 16 cycles apart.
- `WIN_LEN`=16, square wave with period 2 -> 8 edges -> `nrise`=7, `sat`=1.
- `sig_in` already high when `en` rises, then 3 further rising edges -> `nrise`=3; the initial level is not counted.
- Single edges placed in the terminal cycle and in the first cycle of the next window -> each edge counted exactly once, in the correct window.
- `en` dropped at window cycle 10, then re-raised -> no strobe for the aborted window, `nrise` holds its prior value, next strobe arrives WIN_LEN+2 cycles after re-enable.
- Reset asserted mid-window -> outputs return to 0 asynchronously.
